// File: rtl/mem_access_unit.sv
// Load/store unit bridging a valid/ready pipeline port to a single-port word memory.
// Sub-word stores are done as read-modify-write: READ latches the word, WRITE stores the merged word.
module mem_access_unit #(
    parameter int unsigned MAX_ADDR = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_fault,
    output logic        mwr,
    output logic        moe,
    output logic [31:0] ma,
    output logic [31:0] mwd,
    input  logic [31:0] mrd,
    output logic [15:0] fault_count
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    state_t      state_q, state_d;
    logic        we_q, we_d;
    logic [1:0]  size_q, size_d;
    logic        signed_q, signed_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] word_q, word_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        resp_fault_q, resp_fault_d;
    logic [15:0] fault_count_q, fault_count_d;
    logic        req_fault;

    // Replace the addressed lane of a memory word; word stores take wdata whole.
    function automatic logic [31:0] merge_word(input logic [31:0] word, input logic [31:0] wdata,
                                               input logic [1:0] size, input logic [1:0] lane);
        logic [31:0] merged;
        merged = word;
        case (size)
            2'b00:   merged[{lane, 3'b000} +: 8]     = wdata[7:0];
            2'b01:   merged[{lane[1], 4'b0000} +: 16] = wdata[15:0];
            default: merged = wdata;
        endcase
        return merged;
    endfunction

    function automatic logic [31:0] extract_word(input logic [31:0] word, input logic [1:0] size,
                                                 input logic sign_ext, input logic [1:0] lane);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{lane, 3'b000} +: 8];
        h = word[{lane[1], 4'b0000} +: 16];
        case (size)
            2'b00:   return {{24{sign_ext & b[7]}}, b};
            2'b01:   return {{16{sign_ext & h[15]}}, h};
            default: return word;
        endcase
    endfunction

    assign req_fault = (req_size == 2'b11)
                    || (req_size == 2'b01 && req_addr[0])
                    || (req_size == 2'b10 && req_addr[1:0] != 2'b00)
                    || (req_addr > MAX_ADDR);

    always_comb begin
        // NOTE: every *_d defaults to its flop so no path through the case infers a latch.
        state_d       = state_q;
        we_d          = we_q;
        size_d        = size_q;
        signed_d      = signed_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        word_d        = word_q;
        resp_rdata_d  = resp_rdata_q;
        resp_fault_d  = resp_fault_q;
        fault_count_d = fault_count_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d         = req_we;
                    size_d       = req_size;
                    signed_d     = req_signed;
                    addr_d       = req_addr;
                    wdata_d      = req_wdata;
                    resp_rdata_d = 32'h0;
                    resp_fault_d = req_fault;
                    if (req_fault) begin
                        state_d = RESP;
                        if (fault_count_q != 16'hFFFF) fault_count_d = fault_count_q + 16'd1;
                    end else if (req_we && req_size == 2'b10) begin
                        state_d = WRITE;
                    end else begin
                        state_d = READ;
                    end
                end
            end
            READ: begin
                word_d = mrd;
                if (we_q) begin
                    state_d = WRITE;
                end else begin
                    resp_rdata_d = extract_word(mrd, size_q, signed_q, addr_q[1:0]);
                    state_d      = RESP;
                end
            end
            WRITE: state_d = RESP;
            RESP:  if (resp_ready) state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; reset wins over every transition.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            we_q          <= 1'b0;
            size_q        <= 2'b00;
            signed_q      <= 1'b0;
            addr_q        <= 32'h0;
            wdata_q       <= 32'h0;
            word_q        <= 32'h0;
            resp_rdata_q  <= 32'h0;
            resp_fault_q  <= 1'b0;
            fault_count_q <= 16'h0;
        end else begin
            state_q       <= state_d;
            we_q          <= we_d;
            size_q        <= size_d;
            signed_q      <= signed_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            word_q        <= word_d;
            resp_rdata_q  <= resp_rdata_d;
            resp_fault_q  <= resp_fault_d;
            fault_count_q <= fault_count_d;
        end
    end

    // Memory strobes are pure state decode, so they are quiet in IDLE and RESP.
    assign req_ready   = (state_q == IDLE);
    assign resp_valid  = (state_q == RESP);
    assign resp_rdata  = resp_rdata_q;
    assign resp_fault  = resp_fault_q;
    assign moe         = (state_q == READ);
    assign mwr         = (state_q == WRITE);
    assign ma          = (moe || mwr) ? {addr_q[31:2], 2'b00} : 32'h0;
    assign mwd         = mwr ? merge_word(word_q, wdata_q, size_q, addr_q[1:0]) : 32'h0;
    assign fault_count = fault_count_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: a word memory driven by the DUT plus a byte-array reference model.
module tb_mem_access_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_we, req_signed;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_ready, resp_fault;
    logic [31:0] resp_rdata;
    logic        mwr, moe;
    logic [31:0] ma, mwd, mrd;
    logic [15:0] fault_count;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clock = ~clock;

    mem_access_unit #(.MAX_ADDR(255)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_fault(resp_fault), .mwr(mwr), .moe(moe),
        .ma(ma), .mwd(mwd), .mrd(mrd), .fault_count(fault_count)
    );

    // Word memory seen by the DUT, preloadable through a bench-only port.
    logic [31:0] tb_mem [64];
    logic        init_we = 1'b0;
    logic [5:0]  init_idx = 6'd0;
    logic [31:0] init_data = 32'h0;

    always @(posedge clock) begin
        if (init_we) tb_mem[init_idx] <= init_data;
        else if (mwr) tb_mem[ma[7:2]] <= mwd;
    end
    assign mrd = moe ? tb_mem[ma[7:2]] : 32'h0;

    int          mwr_cycles = 0;
    int          moe_cycles = 0;
    logic [31:0] last_ma  = 32'h0;
    logic [31:0] last_mwd = 32'h0;
    always @(negedge clock) begin
        if (mwr === 1'b1) begin
            mwr_cycles++;
            last_ma  = ma;
            last_mwd = mwd;
        end
        if (moe === 1'b1) moe_cycles++;
    end

    // Reference model: byte-addressed memory and plain access rules.
    logic [7:0] ref_mem [256];
    int         ref_faults = 0;

    task automatic ref_access(input logic we, input logic [1:0] size, input logic sgn,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              output logic [31:0] rdata, output logic fault,
                              output int lat, output int n_wr, output int n_rd);
        int nbytes;
        rdata  = 32'h0;
        n_wr   = 0;
        n_rd   = 0;
        nbytes = 1 << size;
        fault  = (size == 2'b11) || (addr > 255) || (addr % nbytes != 0);
        if (fault) begin
            lat = 1;
            if (ref_faults < 65535) ref_faults++;
            return;
        end
        if (we) begin
            for (int i = 0; i < nbytes; i++) ref_mem[addr + i] = wdata[8*i +: 8];
            n_wr = 1;
            n_rd = (nbytes < 4) ? 1 : 0;
            lat  = (nbytes < 4) ? 3 : 2;
        end else begin
            for (int i = 0; i < nbytes; i++) rdata[8*i +: 8] = ref_mem[addr + i];
            if (sgn && nbytes < 4 && rdata[8*nbytes-1])
                for (int i = nbytes; i < 4; i++) rdata[8*i +: 8] = 8'hFF;
            n_rd = 1;
            lat  = 2;
        end
    endtask

    task automatic init_mem();
        for (int w = 0; w < 64; w++) begin
            @(negedge clock);
            init_we   = 1'b1;
            init_idx  = w[5:0];
            init_data = $urandom;
            for (int b = 0; b < 4; b++) ref_mem[4*w + b] = init_data[8*b +: 8];
        end
        @(negedge clock);
        init_we = 1'b0;
    endtask

    // Issue one request, hold the response for `hold` cycles, then release it.
    task automatic do_req(input logic we, input logic [1:0] size, input logic sgn,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input int hold, output logic [31:0] rdata);
        logic [31:0] exp_rdata;
        logic        exp_fault;
        int          exp_lat, exp_wr, exp_rd, wr0, rd0, lat;
        ref_access(we, size, sgn, addr, wdata, exp_rdata, exp_fault, exp_lat, exp_wr, exp_rd);
        wr0 = mwr_cycles;
        rd0 = moe_cycles;
        @(negedge clock);
        req_valid  = 1'b1;
        req_we     = we;
        req_size   = size;
        req_signed = sgn;
        req_addr   = addr;
        req_wdata  = wdata;
        resp_ready = (hold == 0);
        n_cmp++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL req_ready_idle @%h: got %b, expected 1", addr, req_ready);
        end
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        lat = 1;
        while (resp_valid !== 1'b1 && lat < 8) begin
            @(posedge clock);
            #1;
            lat++;
        end
        n_cmp++;
        if (resp_valid !== 1'b1 || lat != exp_lat) begin
            n_fail++;
            $display("FAIL latency @%h we=%b size=%0d: got %0d edges (valid=%b), expected %0d",
                     addr, we, size, lat, resp_valid, exp_lat);
        end
        n_cmp++;
        if (resp_fault !== exp_fault) begin
            n_fail++;
            $display("FAIL resp_fault @%h size=%0d: got %b, expected %b", addr, size, resp_fault, exp_fault);
        end
        n_cmp++;
        if (resp_rdata !== exp_rdata) begin
            n_fail++;
            $display("FAIL resp_rdata @%h we=%b size=%0d sgn=%b: got %h, expected %h",
                     addr, we, size, sgn, resp_rdata, exp_rdata);
        end
        rdata = resp_rdata;
        for (int i = 0; i < hold; i++) begin
            @(posedge clock);
            #1;
            n_cmp++;
            if (resp_valid !== 1'b1 || resp_rdata !== exp_rdata || resp_fault !== exp_fault
                || req_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL hold_stable cycle %0d: got valid=%b rdata=%h ready=%b, expected 1/%h/0",
                         i, resp_valid, resp_rdata, req_ready, exp_rdata);
            end
        end
        resp_ready = 1'b1;
        @(posedge clock);
        #1;
        n_cmp++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL resp_release: got ready=%b valid=%b, expected 1/0", req_ready, resp_valid);
        end
        n_cmp++;
        if (mwr_cycles - wr0 != exp_wr || moe_cycles - rd0 != exp_rd) begin
            n_fail++;
            $display("FAIL mem_strobes @%h: got mwr=%0d moe=%0d cycles, expected %0d/%0d",
                     addr, mwr_cycles - wr0, moe_cycles - rd0, exp_wr, exp_rd);
        end
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_size   = 2'b00;
        req_signed = 1'b0;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        resp_ready = 1'b1;
        init_mem();
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        n_cmp++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_fault !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_handshake: got ready=%b valid=%b fault=%b, expected 1/0/0",
                     req_ready, resp_valid, resp_fault);
        end
        n_cmp++;
        if (resp_rdata !== 32'h0 || fault_count !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_data: got rdata=%h count=%h, expected 0/0", resp_rdata, fault_count);
        end
        n_cmp++;
        if (mwr !== 1'b0 || moe !== 1'b0 || ma !== 32'h0 || mwd !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_mem_port: got mwr=%b moe=%b ma=%h mwd=%h, expected all 0",
                     mwr, moe, ma, mwd);
        end
    endtask

    task automatic test_word_store_load();
        logic [31:0] rd;
        do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 0, rd);
        n_cmp++;
        if (last_ma !== 32'h10 || last_mwd !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL word_store_port: got ma=%h mwd=%h, expected 00000010/deadbeef", last_ma, last_mwd);
        end
        do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 0, rd);
        n_cmp++;
        if (rd !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL word_load: got %h, expected deadbeef", rd);
        end
    endtask

    task automatic test_byte_store();
        logic [31:0] rd;
        do_req(1'b1, 2'b00, 1'b0, 32'h11, 32'h000000AA, 0, rd);
        n_cmp++;
        if (last_ma !== 32'h10 || last_mwd !== 32'hDEADAAEF) begin
            n_fail++;
            $display("FAIL byte_merge: got ma=%h mwd=%h, expected 00000010/deadaaef", last_ma, last_mwd);
        end
    endtask

    task automatic test_sub_loads();
        logic [31:0] rd;
        do_req(1'b0, 2'b00, 1'b1, 32'h11, 32'h0, 0, rd);
        n_cmp++;
        if (rd !== 32'hFFFFFFAA) begin
            n_fail++;
            $display("FAIL signed_byte_load: got %h, expected ffffffaa", rd);
        end
        do_req(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 0, rd);
        n_cmp++;
        if (rd !== 32'h0000DEAD) begin
            n_fail++;
            $display("FAIL unsigned_half_load: got %h, expected 0000dead", rd);
        end
    endtask

    task automatic test_faults();
        logic [31:0] rd;
        do_req(1'b0, 2'b10, 1'b0, 32'h13, 32'h0, 0, rd);
        do_req(1'b0, 2'b01, 1'b0, 32'h101, 32'h0, 0, rd);
        do_req(1'b1, 2'b11, 1'b0, 32'h20, 32'h12345678, 0, rd);
        n_cmp++;
        if (fault_count !== 16'd3) begin
            n_fail++;
            $display("FAIL fault_count_three: got %0d, expected 3", fault_count);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] rd;
        do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 5, rd);
        do_req(1'b1, 2'b01, 1'b0, 32'h22, 32'h0000BEEF, 3, rd);
    endtask

    task automatic test_reset_in_read();
        int          wr0;
        logic [31:0] exp_word;
        exp_word = {ref_mem[51], ref_mem[50], ref_mem[49], ref_mem[48]};
        wr0 = mwr_cycles;
        @(negedge clock);
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_size   = 2'b00;
        req_signed = 1'b0;
        req_addr   = 32'h31;
        req_wdata  = 32'h00000055;
        resp_ready = 1'b1;
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        n_cmp++;
        if (moe !== 1'b1 || ma !== 32'h30) begin
            n_fail++;
            $display("FAIL enter_read: got moe=%b ma=%h, expected 1/00000030", moe, ma);
        end
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        ref_faults = 0;
        n_cmp++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || fault_count !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_from_read: got ready=%b valid=%b count=%0d, expected 1/0/0",
                     req_ready, resp_valid, fault_count);
        end
        repeat (4) @(posedge clock);
        #1;
        n_cmp++;
        if (mwr_cycles != wr0) begin
            n_fail++;
            $display("FAIL no_write_after_reset: got %0d mwr cycles, expected 0", mwr_cycles - wr0);
        end
        n_cmp++;
        if (tb_mem[12] !== exp_word) begin
            n_fail++;
            $display("FAIL word_unchanged: got %h, expected %h", tb_mem[12], exp_word);
        end
    endtask

    task automatic test_random();
        logic [31:0] rd, addr;
        logic [1:0]  size;
        int          r;
        for (int n = 0; n < 40; n++) begin
            r    = $urandom_range(0, 9);
            size = (r < 3) ? 2'b00 : (r < 6) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
            addr = ($urandom_range(0, 9) == 0) ? 32'($urandom_range(256, 300))
                                               : 32'($urandom_range(0, 255));
            if (size != 2'b11 && $urandom_range(0, 3) != 0)
                addr = addr & ~((32'd1 << size) - 32'd1);
            do_req(1'($urandom_range(0, 1)), size, 1'($urandom_range(0, 1)), addr, $urandom,
                   int'($urandom_range(0, 2)), rd);
        end
        n_cmp++;
        if (fault_count !== 16'(ref_faults)) begin
            n_fail++;
            $display("FAIL fault_count_random: got %0d, expected %0d", fault_count, ref_faults);
        end
        for (int w = 0; w < 64; w++) begin
            n_cmp++;
            if (tb_mem[w] !== {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]}) begin
                n_fail++;
                $display("FAIL mem_word[%0d]: got %h, expected %h", w, tb_mem[w],
                         {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]});
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_word_store_load();
        test_byte_store();
        test_sub_loads();
        test_faults();
        test_backpressure();
        test_reset_in_read();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
